// File: rtl/sel_pipe_stage.sv
// Purpose : N-way selector into a valid/ready pipeline register backed by a one-entry skid register.
// Latency : 1 cycle from accept to out_*. Full throughput while out_ready=1.
// Backpres: in_ready is register-derived (~skid_valid & ~rst). A beat that arrives during a stall parks in skid.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   flush        drops every held beat, including one offered in the same cycle
//   in_data      NUM_IN channels, channel k at [k*WIDTH +: WIDTH]
//   sel          channel index, sampled with in_valid
//   in_valid/in_ready    upstream handshake
//   out_data/out_err     selected beat; out_err marks sel >= NUM_IN (data forced to 0)
//   out_valid/out_ready  downstream handshake
module sel_pipe_stage #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2,
    parameter int SEL_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic             r_main_vld;
    logic [WIDTH-1:0] r_main_dat;
    logic             r_main_err;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_skid_dat;
    logic             r_skid_err;

    logic [WIDTH-1:0] w_sel_dat;
    logic             w_sel_err;
    logic             w_acc;
    logic             w_emit;

    // Unmatched select (sel >= NUM_IN) falls through with zero data and err set.
    always_comb begin
        w_sel_dat = '0;
        w_sel_err = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_dat = in_data[k*WIDTH +: WIDTH];
                w_sel_err = 1'b0;
            end
        end
    end

    assign in_ready  = ~r_skid_vld & ~rst;
    assign w_acc     = in_valid & in_ready;
    assign w_emit    = r_main_vld & out_ready;

    assign out_valid = r_main_vld;
    assign out_data  = r_main_dat;
    assign out_err   = r_main_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_vld <= 1'b0;
            r_main_dat <= '0;
            r_main_err <= 1'b0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
            r_skid_err <= 1'b0;
        end else if (flush) begin
            // Data is left alone; it is don't-care once valid drops.
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            // in_ready is low here, so only a drain can happen.
            if (w_emit) begin
                r_main_dat <= r_skid_dat;
                r_main_err <= r_skid_err;
                r_skid_vld <= 1'b0;
            end
        end else if (!r_main_vld || w_emit) begin
            // Main is free this cycle: refill it or go empty.
            r_main_vld <= w_acc;
            if (w_acc) begin
                r_main_dat <= w_sel_dat;
                r_main_err <= w_sel_err;
            end
        end else if (w_acc) begin
            // Main stalled: park the new beat so upstream sees in_ready drop a cycle later.
            r_skid_vld <= 1'b1;
            r_skid_dat <= w_sel_dat;
            r_skid_err <= w_sel_err;
        end
    end

endmodule

// File: tb/tb_sel_pipe_stage.sv
// Purpose : directed and random checks of sel_pipe_stage (WIDTH=5, NUM_IN=3) against a FIFO reference model.
// Latency : model treats the stage as a 2-deep in-order queue with 1-cycle visibility.
// Backpres: model in_ready = fewer than 2 beats held and rst low.
module tb_sel_pipe_stage;

    localparam int WIDTH  = 5;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             err;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    flush = 1'b0;
    logic [NUM_IN*WIDTH-1:0] in_data = '0;
    logic [SEL_W-1:0]        sel = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready = 1'b0;

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t mq[$];

    sel_pipe_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic beat_t ref_beat(logic [NUM_IN*WIDTH-1:0] d, logic [SEL_W-1:0] s);
        beat_t b;
        int    idx;
        idx = int'(s);
        if (idx < NUM_IN) begin
            b.dat = WIDTH'(d >> (idx * WIDTH));
            b.err = 1'b0;
        end else begin
            b.dat = '0;
            b.err = 1'b1;
        end
        return b;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2 && !rst));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(mq[0].dat));
            chk("out_err", 32'(out_err), 32'(mq[0].err));
        end
    endtask

    // One clock: derive handshakes from the model, advance it at the edge, then compare at the falling edge.
    task automatic tick();
        bit    acc;
        bit    emit;
        beat_t b;
        acc  = in_valid && !rst && (mq.size() < 2);
        emit = (mq.size() > 0) && out_ready;
        b    = ref_beat(in_data, sel);
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (emit) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        // 1: reset held for two cycles
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 2: streaming select of all three channels, no bubbles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {5'd31, 5'd7, 5'd3};
        sel = 2'd0; tick(); chk("stream0", 32'(out_data), 32'd3);
        sel = 2'd1; tick(); chk("stream1", 32'(out_data), 32'd7);
        sel = 2'd2; tick(); chk("stream2", 32'(out_data), 32'd31);
        chk("stream2_vld", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // 3: backpressure fills main then skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        in_data   = {5'd0, 5'd0, 5'd10}; tick();
        chk("bp_first_rdy", 32'(in_ready), 32'd1);
        in_data   = {5'd0, 5'd0, 5'd11}; tick();
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        chk("bp_hold", 32'(out_data), 32'd10);
        in_valid = 1'b0;
        tick();
        chk("bp_still_hold", 32'(out_data), 32'd10);
        out_ready = 1'b1;
        tick();
        chk("bp_second", 32'(out_data), 32'd11);
        chk("bp_rdy_back", 32'(in_ready), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // 4: out-of-range select, then recovery
        in_valid = 1'b1;
        in_data  = {5'd9, 5'd5, 5'd2};
        sel = 2'd3; tick();
        chk("bad_sel_dat", 32'(out_data), 32'd0);
        chk("bad_sel_err", 32'(out_err), 32'd1);
        sel = 2'd1; tick();
        chk("good_sel_err", 32'(out_err), 32'd0);
        chk("good_sel_dat", 32'(out_data), 32'd5);
        in_valid = 1'b0;
        tick();

        // 5: flush with both entries full and a beat on offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd0;
        in_data   = {5'd0, 5'd0, 5'd20}; tick();
        in_data   = {5'd0, 5'd0, 5'd21}; tick();
        chk("flush_pre_full", 32'(in_ready), 32'd0);
        flush   = 1'b1;
        in_data = {5'd0, 5'd0, 5'd22};
        tick();
        chk("flush_vld", 32'(out_valid), 32'd0);
        chk("flush_rdy", 32'(in_ready), 32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("flush_no_ghost", 32'(out_valid), 32'd0);
        tick();
        chk("flush_no_ghost2", 32'(out_valid), 32'd0);

        // 6: random traffic with occasional flush and reset
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = NUM_IN*WIDTH'($urandom);
            sel       = SEL_W'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 511) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
